mem_arbiter: RTL and testbench

- Downstream of the rv32i core. Merges the core's instruction-fetch port (mem_i_*) and data port (mem_d_*) onto one shared external memory bus that uses a valid/ready handshake.
- Generates the busy signals the core uses to freeze its fetch and memory stages.
- Returns read data in the exact cycle busy drops, which is when the core samples it.
- Fixed priority: data port first, then instruction port. Includes a bus watchdog.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one valid/ready memory bus between the core's fetch port and data port.
// Data requests win over fetches; a watchdog forces completion of a stuck bus cycle.
module mem_arbiter #(
  parameter int unsigned  TIMEOUT  = 255,
  parameter logic [31:0]  ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_i_addr,
  input  logic        mem_i_rstrb,
  output logic [31:0] mem_i_rdata,
  output logic        mem_i_rbusy,
  input  logic [31:0] mem_d_addr,
  input  logic [31:0] mem_d_wdata,
  input  logic [3:0]  mem_d_wmask,
  input  logic        mem_d_wstrb,
  input  logic        mem_d_rstrb,
  output logic [31:0] mem_d_rdata,
  output logic        mem_d_rbusy,
  output logic        mem_d_wbusy,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    I_BUS    = 3'd1,
    D_RD_BUS = 3'd2,
    D_WR_BUS = 3'd3,
    I_DONE   = 3'd4,
    D_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic        d_pend_q;
  logic        d_we_q;
  logic [29:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic [3:0]  d_wmask_q;
  logic [15:0] wdog_q;
  logic        bus_valid_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_wmask_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        timeout_q;

  logic d_strobe_s;
  logic wdog_expired_s;
  logic addr_lsb_unused;

  assign d_strobe_s      = mem_d_rstrb | mem_d_wstrb;
  assign wdog_expired_s  = (wdog_q == WDOG_LAST);
  assign addr_lsb_unused = ^{mem_i_addr[1:0], mem_d_addr[1:0]};

  assign mem_d_rbusy = d_pend_q & ~d_we_q & (state_q != D_DONE);
  assign mem_d_wbusy = d_pend_q &  d_we_q & (state_q != D_DONE);
  assign mem_i_rbusy = mem_i_rstrb & (state_q != I_DONE);

  assign bus_valid   = bus_valid_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wmask   = bus_wmask_q;
  assign mem_i_rdata = i_rdata_q;
  assign mem_d_rdata = d_rdata_q;
  assign bus_timeout = timeout_q;

  // Single-entry data request holder; a read strobe takes precedence over a write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_pend_q  <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= 30'd0;
      d_wdata_q <= 32'd0;
      d_wmask_q <= 4'd0;
    end else if (state_q == D_DONE) begin
      d_pend_q <= 1'b0;
    end else if (!d_pend_q && d_strobe_s) begin
      d_pend_q  <= 1'b1;
      d_we_q    <= ~mem_d_rstrb;
      d_addr_q  <= mem_d_addr[31:2];
      d_wdata_q <= mem_d_wdata;
      d_wmask_q <= mem_d_wmask;
    end
  end

  // Arbitration FSM with registered bus outputs, read capture and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wdog_q      <= 16'd0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wmask_q <= 4'd0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= 16'd0;
          if (d_pend_q) begin
            bus_valid_q <= 1'b1;
            bus_we_q    <= d_we_q;
            bus_addr_q  <= {d_addr_q, 2'b00};
            bus_wdata_q <= d_wdata_q;
            bus_wmask_q <= d_we_q ? d_wmask_q : 4'b0000;
            state_q     <= d_we_q ? D_WR_BUS : D_RD_BUS;
          end else if (!d_strobe_s && mem_i_rstrb) begin
            // A data strobe this cycle becomes pending next cycle, so the fetch waits.
            bus_valid_q <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {mem_i_addr[31:2], 2'b00};
            bus_wdata_q <= 32'd0;
            bus_wmask_q <= 4'b0000;
            state_q     <= I_BUS;
          end else begin
            state_q <= IDLE;
          end
        end
        I_BUS, D_RD_BUS, D_WR_BUS: begin
          if (bus_ready || wdog_expired_s) begin
            bus_valid_q <= 1'b0;
            wdog_q      <= 16'd0;
            if (!bus_ready) begin
              timeout_q <= 1'b1;
            end
            if (state_q == I_BUS) begin
              i_rdata_q <= bus_ready ? bus_rdata : ERR_DATA;
            end
            if (state_q == D_RD_BUS) begin
              d_rdata_q <= bus_ready ? bus_rdata : ERR_DATA;
            end
            state_q <= (state_q == I_BUS) ? I_DONE : D_DONE;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        I_DONE, D_DONE: begin
          wdog_q  <= 16'd0;
          state_q <= IDLE;
        end
        default: begin
          bus_valid_q <= 1'b0;
          wdog_q      <= 16'd0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store with waits, D/I contention,
// watchdog timeout, and reset in the middle of a bus write.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] mem_i_addr;
  logic        mem_i_rstrb;
  logic [31:0] mem_i_rdata;
  logic        mem_i_rbusy;
  logic [31:0] mem_d_addr;
  logic [31:0] mem_d_wdata;
  logic [3:0]  mem_d_wmask;
  logic        mem_d_wstrb;
  logic        mem_d_rstrb;
  logic [31:0] mem_d_rdata;
  logic        mem_d_rbusy;
  logic        mem_d_wbusy;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_timeout;

  int vectors;
  int miscompares;

  mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_i_addr(mem_i_addr), .mem_i_rstrb(mem_i_rstrb),
    .mem_i_rdata(mem_i_rdata), .mem_i_rbusy(mem_i_rbusy),
    .mem_d_addr(mem_d_addr), .mem_d_wdata(mem_d_wdata), .mem_d_wmask(mem_d_wmask),
    .mem_d_wstrb(mem_d_wstrb), .mem_d_rstrb(mem_d_rstrb),
    .mem_d_rdata(mem_d_rdata), .mem_d_rbusy(mem_d_rbusy), .mem_d_wbusy(mem_d_wbusy),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    mem_i_addr  = 32'd0;
    mem_i_rstrb = 1'b0;
    mem_d_addr  = 32'd0;
    mem_d_wdata = 32'd0;
    mem_d_wmask = 4'd0;
    mem_d_wstrb = 1'b0;
    mem_d_rstrb = 1'b0;
    bus_ready   = 1'b0;
    bus_rdata   = 32'd0;

    #12;
    chk("rst_valid",   {31'd0, bus_valid},   32'd0);
    chk("rst_timeout", {31'd0, bus_timeout}, 32'd0);
    chk("rst_rbusy",   {31'd0, mem_d_rbusy}, 32'd0);
    chk("rst_wbusy",   {31'd0, mem_d_wbusy}, 32'd0);
    chk("rst_addr",    bus_addr,             32'd0);
    chk("rst_irdata",  mem_i_rdata,          32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Fetch, ready on the first valid cycle.
    mem_i_addr = 32'h0000_0010; mem_i_rstrb = 1'b1; bus_rdata = 32'h0000_0013;
    #1;
    chk("f_rbusy0", {31'd0, mem_i_rbusy}, 32'd1);
    chk("f_valid0", {31'd0, bus_valid},   32'd0);
    cyc(); bus_ready = 1'b1; #1;
    chk("f_valid1", {31'd0, bus_valid},   32'd1);
    chk("f_addr",   bus_addr,             32'h0000_0010);
    chk("f_we",     {31'd0, bus_we},      32'd0);
    chk("f_rbusy1", {31'd0, mem_i_rbusy}, 32'd1);
    cyc(); bus_ready = 1'b0; #1;
    chk("f_rbusy2", {31'd0, mem_i_rbusy}, 32'd0);
    chk("f_rdata",  mem_i_rdata,          32'h0000_0013);
    chk("f_valid2", {31'd0, bus_valid},   32'd0);
    mem_i_rstrb = 1'b0;
    cyc();

    // Store with three wait cycles; a second store pulse while pending is ignored.
    mem_d_addr = 32'h0000_0103; mem_d_wdata = 32'hABAB_ABAB; mem_d_wmask = 4'b1000;
    mem_d_wstrb = 1'b1; #1;
    chk("s_wbusy_strobe", {31'd0, mem_d_wbusy}, 32'd0);
    cyc();
    mem_d_addr = 32'h0000_0200; mem_d_wdata = 32'h1111_1111; mem_d_wmask = 4'b0001;
    #1;
    chk("s_wbusy1", {31'd0, mem_d_wbusy}, 32'd1);
    chk("s_valid1", {31'd0, bus_valid},   32'd0);
    cyc(); mem_d_wstrb = 1'b0; #1;
    chk("s_valid",  {31'd0, bus_valid}, 32'd1);
    chk("s_addr",   bus_addr,           32'h0000_0100);
    chk("s_we",     {31'd0, bus_we},    32'd1);
    chk("s_wdata",  bus_wdata,          32'hABAB_ABAB);
    chk("s_wmask",  {28'd0, bus_wmask}, 32'h8);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 3) bus_ready = 1'b1;
      #1;
      chk("s_hold_valid", {31'd0, bus_valid},   32'd1);
      chk("s_hold_addr",  bus_addr,             32'h0000_0100);
      chk("s_hold_wmask", {28'd0, bus_wmask},   32'h8);
      chk("s_hold_wbusy", {31'd0, mem_d_wbusy}, 32'd1);
    end
    cyc(); bus_ready = 1'b0; #1;
    chk("s_done_wbusy", {31'd0, mem_d_wbusy}, 32'd0);
    chk("s_done_valid", {31'd0, bus_valid},   32'd0);
    chk("s_no_timeout", {31'd0, bus_timeout}, 32'd0);
    cyc(); #1;
    chk("s_idle_wbusy", {31'd0, mem_d_wbusy}, 32'd0);
    cyc(); #1;
    chk("s_single_write", {31'd0, bus_valid}, 32'd0);

    // Load and fetch in the same cycle: load first.
    mem_d_addr = 32'h0000_0044; mem_d_rstrb = 1'b1;
    mem_i_addr = 32'h0000_0080; mem_i_rstrb = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("c_irbusy0", {31'd0, mem_i_rbusy}, 32'd1);
    chk("c_drbusy0", {31'd0, mem_d_rbusy}, 32'd0);
    cyc(); mem_d_rstrb = 1'b0; #1;
    chk("c_drbusy1", {31'd0, mem_d_rbusy}, 32'd1);
    chk("c_valid1",  {31'd0, bus_valid},   32'd0);
    cyc(); bus_ready = 1'b1; #1;
    chk("c_dvalid",  {31'd0, bus_valid},   32'd1);
    chk("c_daddr",   bus_addr,             32'h0000_0044);
    chk("c_dwe",     {31'd0, bus_we},      32'd0);
    chk("c_dwmask",  {28'd0, bus_wmask},   32'd0);
    cyc(); bus_ready = 1'b0; #1;
    chk("c_drbusy3", {31'd0, mem_d_rbusy}, 32'd0);
    chk("c_drdata",  mem_d_rdata,          32'hDEAD_BEEF);
    chk("c_irbusy3", {31'd0, mem_i_rbusy}, 32'd1);
    cyc(); bus_rdata = 32'h0000_0093; #1;
    chk("c_idle_valid", {31'd0, bus_valid}, 32'd0);
    cyc(); bus_ready = 1'b1; #1;
    chk("c_ivalid", {31'd0, bus_valid}, 32'd1);
    chk("c_iaddr",  bus_addr,           32'h0000_0080);
    cyc(); bus_ready = 1'b0; #1;
    chk("c_irbusy", {31'd0, mem_i_rbusy}, 32'd0);
    chk("c_irdata", mem_i_rdata,          32'h0000_0093);
    chk("c_dhold",  mem_d_rdata,          32'hDEAD_BEEF);
    mem_i_rstrb = 1'b0;
    cyc();

    // Load with no bus_ready: watchdog completes after 4 valid cycles.
    mem_d_addr = 32'h0000_0300; mem_d_rstrb = 1'b1; bus_rdata = 32'h5555_5555;
    cyc(); mem_d_rstrb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t_valid", {31'd0, bus_valid},   32'd1);
      chk("t_rbusy", {31'd0, mem_d_rbusy}, 32'd1);
    end
    cyc();
    chk("t_done_rbusy", {31'd0, mem_d_rbusy}, 32'd0);
    chk("t_rdata",      mem_d_rdata,          32'h0000_0000);
    chk("t_flag",       {31'd0, bus_timeout}, 32'd1);
    chk("t_valid_off",  {31'd0, bus_valid},   32'd0);
    cyc(); cyc();
    chk("t_sticky", {31'd0, bus_timeout}, 32'd1);

    // Reset while a bus write is outstanding.
    mem_d_addr = 32'h0000_0020; mem_d_wdata = 32'h1234_5678; mem_d_wmask = 4'b1111;
    mem_d_wstrb = 1'b1;
    cyc(); mem_d_wstrb = 1'b0;
    cyc();
    chk("r_valid_pre", {31'd0, bus_valid},   32'd1);
    chk("r_wbusy_pre", {31'd0, mem_d_wbusy}, 32'd1);
    rst = 1'b1; #1;
    chk("r_valid",   {31'd0, bus_valid},   32'd0);
    chk("r_wbusy",   {31'd0, mem_d_wbusy}, 32'd0);
    chk("r_rbusy",   {31'd0, mem_d_rbusy}, 32'd0);
    chk("r_irbusy",  {31'd0, mem_i_rbusy}, 32'd0);
    chk("r_timeout", {31'd0, bus_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    mem_i_addr = 32'h0000_0040; mem_i_rstrb = 1'b1; bus_rdata = 32'h0000_0077; #1;
    chk("r_f_rbusy0", {31'd0, mem_i_rbusy}, 32'd1);
    chk("r_f_valid0", {31'd0, bus_valid},   32'd0);
    cyc(); bus_ready = 1'b1; #1;
    chk("r_f_valid", {31'd0, bus_valid},   32'd1);
    chk("r_f_addr",  bus_addr,             32'h0000_0040);
    chk("r_f_we",    {31'd0, bus_we},      32'd0);
    cyc(); bus_ready = 1'b0; #1;
    chk("r_f_rbusy", {31'd0, mem_i_rbusy}, 32'd0);
    chk("r_f_rdata", mem_i_rdata,          32'h0000_0077);
    mem_i_rstrb = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
